// File: rtl/dpram_be_clr.sv
`default_nettype none
// ============================================================================
// Module : dpram_be_clr
// Brief  : Simple dual-port RAM with byte enables, read-during-write mode,
//          optional output register and a hardware clear engine.
// Rev    : 1.0  initial release
// ============================================================================
module dpram_be_clr #(
  parameter int                    addr_width     = 8,
  parameter int                    data_width     = 8,
  parameter int                    byte_width     = 8,
  parameter int                    NUMWORDS       = 1 << addr_width,
  parameter string                 mem_init_file  = "",
  parameter int                    RDW_MODE       = 0,
  parameter int                    OUT_REG        = 0,
  parameter int                    CLEAR_ON_RESET = 0,
  parameter logic [data_width-1:0] CLEAR_VALUE    = '0
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             wren,
  input  logic [addr_width-1:0]            wraddress,
  input  logic [data_width-1:0]            data,
  input  logic [data_width/byte_width-1:0] byteena,
  input  logic                             rden,
  input  logic [addr_width-1:0]            rdaddress,
  input  logic                             clear,
  output logic [data_width-1:0]            q,
  output logic                             q_valid,
  output logic                             busy
);

  localparam int                    c_LANES     = data_width / byte_width;
  localparam logic [0:0]            c_ST_IDLE   = 1'b0;
  localparam logic [0:0]            c_ST_CLEAR  = 1'b1;
  localparam logic [0:0]            c_ST_RESET  = (CLEAR_ON_RESET != 0) ? c_ST_CLEAR : c_ST_IDLE;
  localparam logic [addr_width-1:0] c_LAST_ADDR = addr_width'(NUMWORDS - 1);
  localparam logic [addr_width:0]   c_DEPTH     = (addr_width + 1)'(NUMWORDS);

  logic [data_width-1:0] r_mem [0:NUMWORDS-1];

  logic [0:0]            r_state;
  logic [0:0]            w_state_next;
  logic [addr_width-1:0] r_clr_addr;
  logic [addr_width-1:0] w_clr_addr_next;
  logic                  w_clr_last;
  logic                  w_busy;

  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_rdw_hit;
  logic [data_width-1:0] w_wr_mask;
  logic [data_width-1:0] w_rd_old;
  logic [data_width-1:0] w_rd_merged;
  logic [data_width-1:0] w_rd_word;

  logic [data_width-1:0] r_rd_data;
  logic                  r_rd_valid;

  // --------------------------------------------------------------------------
  // Clear engine FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= c_ST_RESET;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
    end
  end

  assign w_clr_last = (r_clr_addr == c_LAST_ADDR);

  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    case (r_state)
      c_ST_IDLE: begin
        w_clr_addr_next = '0;
        if (clear) begin
          w_state_next = c_ST_CLEAR;
        end
      end
      c_ST_CLEAR: begin
        // Terminal compare against the implemented depth, so odd depths never wrap
        if (w_clr_last) begin
          w_state_next    = c_ST_IDLE;
          w_clr_addr_next = '0;
        end else begin
          w_clr_addr_next = r_clr_addr + 1'b1;
        end
      end
      default: begin
        w_state_next    = c_ST_IDLE;
        w_clr_addr_next = '0;
      end
    endcase
  end

  always_comb begin
    w_busy = (r_state == c_ST_CLEAR);
  end

  assign busy = w_busy;

  // --------------------------------------------------------------------------
  // Write port
  // --------------------------------------------------------------------------
  assign w_wr_in_range = ({1'b0, wraddress} < c_DEPTH);
  assign w_rd_in_range = ({1'b0, rdaddress} < c_DEPTH);
  assign w_wr_en       = wren && !w_busy && w_wr_in_range;
  assign w_rd_en       = rden && !w_busy;

  for (genvar g = 0; g < c_LANES; g++) begin : g_lane_mask
    assign w_wr_mask[g*byte_width +: byte_width] = {byte_width{byteena[g]}};
  end

  always_ff @(posedge clock) begin
    if (w_busy) begin
      r_mem[r_clr_addr] <= CLEAR_VALUE;
    end else if (w_wr_en) begin
      for (int i = 0; i < c_LANES; i++) begin
        if (byteena[i]) begin
          r_mem[wraddress][i*byte_width +: byte_width] <= data[i*byte_width +: byte_width];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read port
  // --------------------------------------------------------------------------
  assign w_rd_old    = r_mem[rdaddress];
  assign w_rd_merged = (data & w_wr_mask) | (w_rd_old & ~w_wr_mask);
  assign w_rdw_hit   = (RDW_MODE != 0) && w_wr_en && (wraddress == rdaddress);

  always_comb begin
    w_rd_word = w_rd_old;
    if (!w_rd_in_range) begin
      w_rd_word = '0;
    end else if (w_rdw_hit) begin
      w_rd_word = w_rd_merged;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (w_rd_en) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  // Optional second stage: q only advances when a valid word arrives
  if (OUT_REG != 0) begin : g_out_reg
    logic [data_width-1:0] r_q;
    logic                  r_q_valid;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_q       <= '0;
        r_q_valid <= 1'b0;
      end else begin
        r_q_valid <= r_rd_valid;
        if (r_rd_valid) begin
          r_q <= r_rd_data;
        end
      end
    end

    assign q       = r_q;
    assign q_valid = r_q_valid;
  end else begin : g_no_out_reg
    assign q       = r_rd_data;
    assign q_valid = r_rd_valid;
  end

endmodule
`default_nettype wire

// File: tb/tb_dpram_be_clr.sv
`default_nettype none
// ============================================================================
// Module : tb_dpram_be_clr
// Brief  : Scoreboard bench; instance A = old-data RDW, latency 1, manual clear;
//          instance B = merged RDW, latency 2, clear on reset.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dpram_be_clr;

  localparam int          c_NW  = 16;
  localparam logic [31:0] c_CLR = 32'h0000_005A;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n [2];
  logic        wren  [2];
  logic        rden  [2];
  logic        clr   [2];
  logic [4:0]  wa    [2];
  logic [4:0]  ra    [2];
  logic [31:0] wd    [2];
  logic [3:0]  be    [2];
  logic [31:0] q     [2];
  logic        qv    [2];
  logic        busy  [2];

  logic [31:0] mdl [2][c_NW];
  sb_t         sb0 [$];
  sb_t         sb1 [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  dpram_be_clr #(
    .addr_width(5), .data_width(32), .byte_width(8), .NUMWORDS(c_NW),
    .mem_init_file(""), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(0),
    .CLEAR_VALUE(c_CLR)
  ) u_a (
    .clock(clk), .reset_n(rst_n[0]), .wren(wren[0]), .wraddress(wa[0]),
    .data(wd[0]), .byteena(be[0]), .rden(rden[0]), .rdaddress(ra[0]),
    .clear(clr[0]), .q(q[0]), .q_valid(qv[0]), .busy(busy[0])
  );

  dpram_be_clr #(
    .addr_width(4), .data_width(32), .byte_width(8), .NUMWORDS(c_NW),
    .mem_init_file(""), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1),
    .CLEAR_VALUE(c_CLR)
  ) u_b (
    .clock(clk), .reset_n(rst_n[1]), .wren(wren[1]), .wraddress(wa[1][3:0]),
    .data(wd[1]), .byteena(be[1]), .rden(rden[1]), .rdaddress(ra[1][3:0]),
    .clear(clr[1]), .q(q[1]), .q_valid(qv[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    merge = o;
    for (int i = 0; i < 4; i++) if (b[i]) merge[i*8 +: 8] = n[i*8 +: 8];
  endfunction

  task automatic sb_push(input int k, input logic [31:0] d, input int due);
    sb_t e;
    e.data = d;
    e.due  = due;
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // One cycle of stimulus, driven at a falling edge; ign marks cycles the DUT must ignore
  task automatic op(input int k, input bit we, input int wadr, input logic [31:0] wdat,
                    input logic [3:0] ben, input bit re, input int radr,
                    input bit clr_req, input bit ign);
    logic [31:0] exp;
    int          lat;
    lat     = (k == 0) ? 1 : 2;
    wren[k] = we;  wa[k] = 5'(wadr); wd[k] = wdat; be[k] = ben;
    rden[k] = re;  ra[k] = 5'(radr); clr[k] = clr_req;
    if (!ign) begin
      if (re) begin
        if (radr >= c_NW) exp = '0;
        else begin
          exp = mdl[k][radr];
          if (k == 1 && we && wadr == radr) exp = merge(exp, wdat, ben);
        end
        sb_push(k, exp, cyc + lat);
      end
      if (we && wadr < c_NW) mdl[k][wadr] = merge(mdl[k][wadr], wdat, ben);
      if (clr_req) for (int i = 0; i < c_NW; i++) mdl[k][i] = c_CLR;
    end
    @(negedge clk);
    wren[k] = 1'b0; rden[k] = 1'b0; clr[k] = 1'b0;
  endtask

  task automatic wr(input int k, input int a, input logic [31:0] d, input logic [3:0] b);
    op(k, 1'b1, a, d, b, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic rd(input int k, input int a);
    op(k, 1'b0, 0, 32'h0, 4'h0, 1'b1, a, 1'b0, 1'b0);
  endtask

  task automatic count_busy(input int k, output int n);
    n = 0;
    while (busy[k] && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic mon(input int k);
    sb_t e;
    int  n;
    n = (k == 0) ? sb0.size() : sb1.size();
    if (qv[k]) begin
      if (n == 0) check($sformatf("unexpected_valid_%0d", k), 32'(qv[k]), 32'h0);
      else begin
        if (k == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        check($sformatf("q_data_%0d", k), q[k], e.data);
        check($sformatf("q_latency_%0d", k), 32'(cyc), 32'(e.due));
      end
    end else if (n != 0) begin
      e = (k == 0) ? sb0[0] : sb1[0];
      if (e.due <= cyc) begin
        if (k == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
        check($sformatf("missing_valid_%0d", k), 32'(qv[k]), 32'h1);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon(0);
      mon(1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; wren[k] = 1'b0; rden[k] = 1'b0; clr[k] = 1'b0;
      wa[k] = '0; ra[k] = '0; wd[k] = '0; be[k] = '0;
    end
    repeat (3) @(negedge clk);
    check("a_rst_q", q[0], 32'h0);
    check("a_rst_qv", 32'(qv[0]), 32'h0);
    check("a_rst_busy", 32'(busy[0]), 32'h0);
    check("b_rst_q", q[1], 32'h0);
    check("b_rst_qv", 32'(qv[1]), 32'h0);
    check("b_rst_busy", 32'(busy[1]), 32'h1);

    // Instance A: byte-lane merge, collision (old data), range limits
    rst_n[0] = 1'b1;
    @(negedge clk);
    wr(0, 5, 32'h1122_3344, 4'hF);
    wr(0, 5, 32'hAABB_CCDD, 4'b0101);
    rd(0, 5);
    wr(0, 5, 32'hFFFF_FFFF, 4'h0);
    rd(0, 5);
    wr(0, 7, 32'h0, 4'hF);
    op(0, 1'b1, 7, 32'hFFFF_FFFF, 4'b0011, 1'b1, 7, 1'b0, 1'b0);
    rd(0, 7);
    wr(0, 4, 32'h4444_4444, 4'hF);
    op(0, 1'b1, 20, 32'hDEAD_BEEF, 4'hF, 1'b1, 20, 1'b0, 1'b0);
    rd(0, 4);

    // Instance A: fill, then clear with a read in flight and traffic during busy
    for (int i = 0; i < c_NW; i++) wr(0, i, 32'hFFFF_FFFF, 4'hF);
    op(0, 1'b0, 0, 32'h0, 4'h0, 1'b1, 3, 1'b1, 1'b0);
    n = 0;
    while (busy[0] && n < 100) begin
      n++;
      op(0, 1'b1, n % c_NW, 32'h1234_5678, 4'hF, 1'b1, 2, 1'b0, 1'b1);
    end
    check("a_busy_len", 32'(n), 32'd16);
    check("a_q_hold", q[0], 32'hFFFF_FFFF);
    for (int i = 0; i < c_NW; i++) rd(0, i);

    // Instance B: clear on reset release
    rst_n[1] = 1'b1;
    count_busy(1, n);
    check("b_busy_por", 32'(n), 32'd16);
    for (int i = 0; i < c_NW; i++) mdl[1][i] = c_CLR;
    wr(1, 7, 32'h0, 4'hF);
    op(1, 1'b1, 7, 32'hFFFF_FFFF, 4'b0011, 1'b1, 7, 1'b0, 1'b0);
    wr(1, 0, 32'hA, 4'hF);
    wr(1, 1, 32'hB, 4'hF);
    wr(1, 2, 32'hC, 4'hF);
    rd(1, 0);
    rd(1, 1);
    rd(1, 2);
    repeat (3) @(negedge clk);

    // Reset while a read is in the output pipeline
    rd(1, 1);
    rst_n[1] = 1'b0;
    sb1.delete();
    #1;
    check("b_midread_q", q[1], 32'h0);
    check("b_midread_qv", 32'(qv[1]), 32'h0);
    check("b_midread_busy", 32'(busy[1]), 32'h1);
    repeat (3) @(negedge clk);

    // Reset in the middle of the power-on clear, then a full restart
    rst_n[1] = 1'b1;
    repeat (8) @(negedge clk);
    check("b_busy_mid", 32'(busy[1]), 32'h1);
    rst_n[1] = 1'b0;
    #1;
    check("b_abort_q", q[1], 32'h0);
    check("b_abort_qv", 32'(qv[1]), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    count_busy(1, n);
    check("b_busy_restart", 32'(n), 32'd16);
    for (int i = 0; i < c_NW; i++) mdl[1][i] = c_CLR;
    for (int i = 0; i < c_NW; i++) rd(1, i);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb0.size() + sb1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
